// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: fetches one word at PC and holds decoded fields until retired.
// Optional ack-timeout logic is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC       = 32'd0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        advance,
    input  logic [31:0] pc_next,
    output logic [31:0] PCout,
    output logic        instr_valid,
    output logic [6:0]  op,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [1:0]  funct2,
    output logic [6:0]  funct7,
    output logic [11:0] imm12,
    output logic [19:0] immhi,
    output logic        instr_illegal,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [6:0]  op_q;
    logic [31:7] word_q;
    logic        ill_q;
    logic        op_ok;
    logic        load_fields;
    logic        set_ill;
    logic        load_pc;
    logic        set_err;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_q;
    logic          err_q;
    logic          limit_hit;

    assign limit_hit = (wait_q == LIMIT);

    // Wait counter runs only in REQ, so it is zero on every REQ entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (state_q == REQ && !imem_ack) begin
            wait_q <= wait_q + 1'b1;
        end else begin
            wait_q <= '0;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    logic limit_hit;

    assign limit_hit = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // Opcodes this front end is allowed to hand to the controller
    always_comb begin
        op_ok = 1'b0;
        unique case (imem_data[6:0])
            7'b0000011: op_ok = 1'b1;
            7'b0010011: op_ok = 1'b1;
            7'b0110011: op_ok = 1'b1;
            7'b0110111: op_ok = 1'b1;
            default:    op_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        load_fields = 1'b0;
        set_ill     = 1'b0;
        load_pc     = 1'b0;
        set_err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (op_ok) begin
                        load_fields = 1'b1;
                        state_d     = VALID;
                    end else begin
                        set_ill = 1'b1;
                        state_d = ERROR;
                    end
                end else if (limit_hit) begin
                    set_err = 1'b1;
                    state_d = ERROR;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (advance) begin
                    load_pc = 1'b1;
                    state_d = REQ;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // PC register, replaced verbatim on retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load_pc) begin
            pc_q <= pc_next;
        end
    end

    // Decoded fields; an illegal opcode only clears op, the rest stay stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            word_q <= '0;
        end else if (load_fields) begin
            op_q   <= imem_data[6:0];
            word_q <= imem_data[31:7];
        end else if (set_ill) begin
            op_q   <= '0;
        end
    end

    // Sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_q <= 1'b0;
        end else if (set_ill) begin
            ill_q <= 1'b1;
        end
    end

    assign imem_addr     = pc_q;
    assign PCout         = pc_q;
    assign instr_illegal = ill_q;
    assign op            = op_q;
    assign rd            = word_q[11:7];
    assign funct3        = word_q[14:12];
    assign rs1           = word_q[19:15];
    assign rs2           = word_q[24:20];
    assign funct2        = word_q[26:25];
    assign funct7        = word_q[31:25];
    assign imm12         = word_q[31:20];
    assign immhi         = word_q[31:12];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed stimulus, per-cycle model compare, literal checks.
// Define FETCH_TIMEOUT_EN to exercise the timeout build.
module tb_instr_fetch_decode;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif
    localparam logic [31:0] RPC = 32'd0;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        advance;
    logic [31:0] pc_next;
    logic [31:0] PCout;
    logic        instr_valid;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  funct2;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    logic [19:0] immhi;
    logic        instr_illegal;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    instr_fetch_decode #(
        .RESET_PC(RPC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_data(imem_data),
        .advance(advance),
        .pc_next(pc_next),
        .PCout(PCout),
        .instr_valid(instr_valid),
        .op(op),
        .rd(rd),
        .funct3(funct3),
        .rs1(rs1),
        .rs2(rs2),
        .funct2(funct2),
        .funct7(funct7),
        .imm12(imm12),
        .immhi(immhi),
        .instr_illegal(instr_illegal),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what the block is doing, the last accepted word,
    // and the sticky flags, advanced by the stated rules each rising edge.
    // phase: 0 waiting to start, 1 fetching, 2 presenting, 3 halted
    int          m_phase;
    int          m_wait;
    logic [31:0] m_pc;
    logic [31:0] m_word;
    logic        m_opzero;
    logic        m_ill;
    logic        m_err;

    function automatic bit supported(input logic [31:0] w);
        logic [6:0] o;
        o = w[6:0];
        return (o == 7'h03) || (o == 7'h13) || (o == 7'h33) || (o == 7'h37);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  = 0;
            m_wait   = 0;
            m_pc     = RPC;
            m_word   = 32'd0;
            m_opzero = 1'b0;
            m_ill    = 1'b0;
            m_err    = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    m_phase = 1;
                    m_wait  = 0;
                end
                1: begin
                    if (imem_ack) begin
                        if (supported(imem_data)) begin
                            m_word   = imem_data;
                            m_opzero = 1'b0;
                            m_phase  = 2;
                        end else begin
                            m_ill    = 1'b1;
                            m_opzero = 1'b1;
                            m_phase  = 3;
                        end
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        m_wait = m_wait + 1;
                        if (m_wait == TMO) begin
                            m_err   = 1'b1;
                            m_phase = 3;
                        end
`endif
                    end
                end
                2: begin
                    if (advance) begin
                        m_pc    = pc_next;
                        m_wait  = 0;
                        m_phase = 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Compare every output with the model on each falling edge
    always @(negedge clk) begin
        chk("cmp_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
        chk("cmp_valid", {31'd0, instr_valid}, {31'd0, m_phase == 2});
        chk("cmp_addr", imem_addr, m_pc);
        chk("cmp_pcout", PCout, m_pc);
        chk("cmp_op", {25'd0, op}, m_opzero ? 32'd0 : {25'd0, m_word[6:0]});
        chk("cmp_rd", {27'd0, rd}, {27'd0, m_word[11:7]});
        chk("cmp_f3", {29'd0, funct3}, {29'd0, m_word[14:12]});
        chk("cmp_rs1", {27'd0, rs1}, {27'd0, m_word[19:15]});
        chk("cmp_rs2", {27'd0, rs2}, {27'd0, m_word[24:20]});
        chk("cmp_f2", {30'd0, funct2}, {30'd0, m_word[26:25]});
        chk("cmp_f7", {25'd0, funct7}, {25'd0, m_word[31:25]});
        chk("cmp_imm12", {20'd0, imm12}, {20'd0, m_word[31:20]});
        chk("cmp_immhi", {12'd0, immhi}, {12'd0, m_word[31:12]});
        chk("cmp_ill", {31'd0, instr_illegal}, {31'd0, m_ill});
        chk("cmp_err", {31'd0, fetch_err}, {31'd0, m_err});
    end

    // Wait (bounded) for a request, then ack it for exactly one cycle
    task automatic ack_word(input logic [31:0] w);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait", {31'd0, imem_req}, 32'd1);
        imem_ack  = 1'b1;
        imem_data = w;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 32'hDEAD_BEEF;
    endtask

    task automatic pulse_adv(input logic [31:0] pc);
        advance = 1'b1;
        pc_next = pc;
        @(negedge clk);
        advance = 1'b0;
        pc_next = 32'h5555_AAAA;
    endtask

    initial begin
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 32'd0;
        advance   = 1'b0;
        pc_next   = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", PCout, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);

        // addi x1,x0,5
        ack_word(32'h0050_0093);
        chk("addi_valid", {31'd0, instr_valid}, 32'd1);
        chk("addi_op", {25'd0, op}, 32'h13);
        chk("addi_rd", {27'd0, rd}, 32'd1);
        chk("addi_f3", {29'd0, funct3}, 32'd0);
        chk("addi_rs1", {27'd0, rs1}, 32'd0);
        chk("addi_imm", {20'd0, imm12}, 32'h005);
        chk("addi_pc", PCout, 32'd0);

        // sub x2,x1,x2 at PC 1
        pulse_adv(32'd1);
        chk("adv_req", {31'd0, imem_req}, 32'd1);
        chk("adv_addr", imem_addr, 32'd1);
        chk("adv_valid", {31'd0, instr_valid}, 32'd0);
        ack_word(32'h4020_8133);
        chk("sub_f7", {25'd0, funct7}, 32'h20);
        chk("sub_rs2", {27'd0, rs2}, 32'd2);
        chk("sub_rs1", {27'd0, rs1}, 32'd1);
        chk("sub_rd", {27'd0, rd}, 32'd2);
        chk("sub_f3", {29'd0, funct3}, 32'd0);

        // lui x1, stray ack while presenting, then 10 idle cycles
        pulse_adv(32'd2);
        ack_word(32'h1234_50B7);
        chk("lui_op", {25'd0, op}, 32'h37);
        chk("lui_immhi", {12'd0, immhi}, 32'h12345);
        chk("lui_rd", {27'd0, rd}, 32'd1);
        imem_ack  = 1'b1;
        imem_data = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ack  = 1'b0;
        repeat (9) @(negedge clk);
        chk("hold_op", {25'd0, op}, 32'h37);
        chk("hold_immhi", {12'd0, immhi}, 32'h12345);
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_pc", PCout, 32'd2);

        // Top of address space, then wrap to 0
        pulse_adv(32'hFFFF_FFFF);
        chk("top_addr", imem_addr, 32'hFFFF_FFFF);
        ack_word(32'h0000_2183);
        chk("lw_op", {25'd0, op}, 32'h03);
        chk("lw_f3", {29'd0, funct3}, 32'd2);
        chk("lw_pc", PCout, 32'hFFFF_FFFF);
        pulse_adv(32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        ack_word(32'h0050_0093);

        // Reset in the middle of a fetch at PC 7
        pulse_adv(32'd7);
        @(negedge clk);
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        chk("mid_addr", imem_addr, 32'd7);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_pc", PCout, RPC);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, RPC);

        // jal is not supported: halts, later advance ignored
        ack_word(32'h0000_006F);
        chk("jal_ill", {31'd0, instr_illegal}, 32'd1);
        chk("jal_op", {25'd0, op}, 32'd0);
        chk("jal_valid", {31'd0, instr_valid}, 32'd0);
        pulse_adv(32'd9);
        repeat (3) @(negedge clk);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_pc", PCout, 32'd0);

        rst_n = 1'b0;
        @(negedge clk);
        chk("clr_ill", {31'd0, instr_illegal}, 32'd0);
        rst_n = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        repeat (5) @(negedge clk);
        chk("tmo_err", {31'd0, fetch_err}, 32'd1);
        chk("tmo_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        imem_ack  = 1'b1;
        imem_data = 32'h0050_0093;
        @(negedge clk);
        imem_ack  = 1'b0;
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd1);
        chk("late_ack_err", {31'd0, fetch_err}, 32'd0);
`else
        repeat (1000) @(negedge clk);
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        chk("wait_err", {31'd0, fetch_err}, 32'd0);
`endif
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
